gf227_frame_acc: RTL and testbench

GF227_FRAME_ACC -- requirements
Module: gf227_frame_acc

---
 rtl/gf227_pkg.sv | 17 +
 rtl/gf227_mod_add.sv | 25 ++
 rtl/gf227_frame_acc.sv | 146 ++++++++++++++
 tb/tb_gf227_frame_acc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf227_pkg.sv
// Shared constants and FSM state type for the GF(227) frame accumulator.
package gf227_pkg;

    localparam int GF_Q = 227;
    localparam int GF_W = 8;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

    // True when a residue lies outside the canonical range [0, q).
    function automatic logic out_of_range(input logic [GF_W-1:0] value, input int q);
        return ({24'd0, value} >= q[31:0]);
    endfunction

endpackage

// File: rtl/gf227_mod_add.sv
// Combinational modular adder: y = (a + b) mod Q for a, b < Q.
module gf227_mod_add
    import gf227_pkg::*;
#(
    parameter int W = GF_W,
    parameter int Q = GF_Q
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [W:0] sum_s;

    // One-extra-bit sum followed by a single conditional subtraction of Q.
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s >= (W+1)'(Q)) begin
            y = W'(sum_s - (W+1)'(Q));
        end else begin
            y = sum_s[W-1:0];
        end
    end

endmodule

// File: rtl/gf227_frame_acc.sv
// Sums FRAME_LEN residues mod Q per frame and holds the result for a consumer.
// Optional input range check/fold enabled by GF227_FRAME_ACC_RANGE_CHECK_EN.
module gf227_frame_acc
    import gf227_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int Q         = GF_Q,
    parameter int W         = GF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         err
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    acc_state_e     state_r;
    acc_state_e     state_nxt_s;
    logic [W-1:0]   acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]   out_data_r;
    logic           out_valid_r;
    logic           err_r;
    logic           ready_en_r;

    logic [W-1:0]   addend_s;
    logic [W-1:0]   sum_s;
    logic           range_bad_s;
    logic           in_ready_s;
    logic           accept_s;
    logic           last_beat_s;
    logic           out_fire_s;

`ifdef GF227_FRAME_ACC_RANGE_CHECK_EN
    // Fold an out-of-range residue back below Q before it reaches the adder.
    always_comb begin
        range_bad_s = (in_data >= W'(Q));
        if (range_bad_s) begin
            addend_s = in_data - W'(Q);
        end else begin
            addend_s = in_data;
        end
    end
`else
    // No range handling: the residue is trusted as delivered.
    always_comb begin
        range_bad_s = 1'b0;
        addend_s    = in_data;
    end
`endif

    gf227_mod_add #(
        .W (W),
        .Q (Q)
    ) u_mod_add (
        .a (acc_r),
        .b (addend_s),
        .y (sum_s)
    );

    // Handshake qualifiers; ready stays low until the first edge after reset.
    always_comb begin
        in_ready_s  = ready_en_r && (state_r == ST_ACC) && !clr;
        accept_s    = in_valid && in_ready_s;
        last_beat_s = (cnt_r == LAST_CNT);
        out_fire_s  = out_valid_r && out_ready;
    end

    // Next-state logic for the accumulate/hold FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACC: begin
                if (accept_s && last_beat_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_fire_s) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_ACC;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accumulator, beat counter, result holding register and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= {W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_data_r  <= {W{1'b0}};
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            ready_en_r  <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (accept_s && range_bad_s) begin
                err_r <= 1'b1;
            end
            if (accept_s) begin
                if (last_beat_s) begin
                    out_data_r  <= sum_s;
                    out_valid_r <= 1'b1;
                    acc_r       <= {W{1'b0}};
                    cnt_r       <= {CNT_W{1'b0}};
                end else begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else if ((state_r == ST_ACC) && clr) begin
                acc_r <= {W{1'b0}};
                cnt_r <= {CNT_W{1'b0}};
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign err       = err_r;

endmodule

// File: tb/tb_gf227_frame_acc.sv
// Self-checking bench for gf227_frame_acc: directed scenarios plus random traffic
// checked every cycle against a frame-sum reference model.
module tb_gf227_frame_acc;

    localparam int FRAME_LEN = 16;
    localparam int Q         = 227;
    localparam int W         = 8;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         err;

    gf227_frame_acc #(
        .FRAME_LEN (FRAME_LEN),
        .Q         (Q),
        .W         (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: beats of the frame in progress and the pending result.
    int beats_q[$];
    bit hold_m     = 1'b0;
    bit ready_m    = 1'b0;
    bit err_m      = 1'b0;
    int exp_out    = 0;
    int n_out      = 0;
    int last_dut   = -1;
    int last_model = -1;

`ifdef GF227_FRAME_ACC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            beats_q.delete();
            hold_m  = 1'b0;
            ready_m = 1'b0;
            err_m   = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, ready_m && !hold_m && !clr});
            chk("out_valid", {31'd0, out_valid}, {31'd0, hold_m});
            if (hold_m) chk("out_data", {24'd0, out_data}, exp_out);
            chk("err", {31'd0, err}, {31'd0, err_m});
            if (hold_m) begin
                if (out_ready) begin
                    hold_m     = 1'b0;
                    n_out++;
                    last_dut   = int'(out_data);
                    last_model = exp_out;
                end
            end else if (clr) begin
                beats_q.delete();
            end else if (in_valid && ready_m) begin
                if (RANGE_EN && int'(in_data) >= Q) begin
                    beats_q.push_back(int'(in_data) - Q);
                    err_m = 1'b1;
                end else begin
                    beats_q.push_back(int'(in_data));
                end
                if (beats_q.size() == FRAME_LEN) begin
                    int s;
                    s = 0;
                    foreach (beats_q[i]) s += beats_q[i];
                    exp_out = s % Q;
                    hold_m  = 1'b1;
                    beats_q.delete();
                end
            end
            ready_m = 1'b1;
        end
    end

    task automatic send(input int d);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = W'(d);
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        for (int t = 0; t < 200 && n_out < target; t++) begin
            @(posedge clk);
            #1;
        end
        if (n_out < target) chk("out_timeout", n_out, target);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;

        // 16 x 226 -> 211
        for (int i = 0; i < FRAME_LEN; i++) send(226);
        wait_out(1);
        chk("f226_dut", last_dut, 211);
        chk("f226_model", last_model, 211);

        // 100 + 127 wraps exactly to 0
        send(100);
        send(127);
        for (int i = 0; i < FRAME_LEN - 2; i++) send(0);
        wait_out(2);
        chk("wrapq_dut", last_dut, 0);
        chk("wrapq_model", last_model, 0);

        // Backpressure: result held for 5 cycles, then transferred
        out_ready = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) send(7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_data", {24'd0, out_data}, 32'd112);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_count", n_out, 3);
        @(negedge clk);
        chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // clr together with a beat drops that beat and restarts the frame
        for (int i = 0; i < 3; i++) send(50);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd50;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) send(1);
        wait_out(4);
        chk("clr_dut", last_dut, 16);
        chk("clr_model", last_model, 16);

        // Out-of-range beat
        send(230);
        for (int i = 0; i < FRAME_LEN - 1; i++) send(0);
        wait_out(5);
        chk("range_out", last_dut, 3);
        chk("range_err", {31'd0, err}, {31'd0, RANGE_EN});

        // Reset mid-frame, then a clean frame
        for (int i = 0; i < 8; i++) send(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) send(1);
        wait_out(6);
        chk("post_rst_dut", last_dut, 16);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = RANGE_EN ? W'($urandom_range(0, 255)) : W'($urandom_range(0, Q - 1));
            clr       = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("random_frames_seen", {31'd0, n_out > 20}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
